// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared entry type and constants for the fetch queue
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          ISSUE_W   = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch-side and decode-side signals of the fetch queue
interface fetch_queue_if #(parameter int DEPTH = 8);
  localparam int PTR_W = $clog2(DEPTH);

  logic              ValidF1;
  logic [31:0]       InstrF1;
  logic [31:0]       PCF1;
  logic              ValidF2;
  logic [31:0]       InstrF2;
  logic [31:0]       PCF2;
  logic              ReadyF;
  logic              ValidD1;
  logic [31:0]       InstrD1;
  logic [31:0]       PCD1;
  logic              ValidD2;
  logic [31:0]       InstrD2;
  logic [31:0]       PCD2;
  logic [1:0]        DeqCnt;
  logic [PTR_W:0]    Count;

  modport master (
    output ValidF1, InstrF1, PCF1, ValidF2, InstrF2, PCF2, DeqCnt,
    input  ReadyF, ValidD1, InstrD1, PCD1, ValidD2, InstrD2, PCD2, Count
  );

  modport slave (
    input  ValidF1, InstrF1, PCF1, ValidF2, InstrF2, PCF2, DeqCnt,
    output ReadyF, ValidD1, InstrD1, PCD1, ValidD2, InstrD2, PCD2, Count
  );
endinterface

// File: rtl/fq_storage.sv
// rtl/fq_storage.sv - 2-write/2-read register array of fetch queue entries
module fq_storage
  import fetch_pkg::*;
#(
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we0,
  input  logic [PTR_W-1:0] widx0,
  input  fq_entry_t        wdata0,
  input  logic             we1,
  input  logic [PTR_W-1:0] widx1,
  input  fq_entry_t        wdata1,
  input  logic [PTR_W-1:0] ridx0,
  input  logic [PTR_W-1:0] ridx1,
  output fq_entry_t        rdata0,
  output fq_entry_t        rdata1
);

  fq_entry_t mem_q [DEPTH];
  fq_entry_t mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we0) mem_d[widx0] = wdata0;
    if (we1) mem_d[widx1] = wdata1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '{pc: 32'h0, instr: NOP_INSTR};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata0 = mem_q[ridx0];
  assign rdata1 = mem_q[ridx1];

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - dual-issue instruction buffer between fetch and decode
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  fetch_queue_if.slave  fq
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             ready;
  logic [1:0]       enq, deq_req, deq;
  logic             we0, we1;
  fq_entry_t        wdata0, wdata1, rdata0, rdata1;

  always_comb begin
    ready   = count_q <= CNT_W'(DEPTH - ISSUE_W);
    enq     = 2'd0;
    if (ready && fq.ValidF1) enq = fq.ValidF2 ? 2'd2 : 2'd1;
    deq_req = (fq.DeqCnt == 2'd3) ? 2'd2 : fq.DeqCnt;
    deq     = (CNT_W'(deq_req) > count_q) ? count_q[1:0] : deq_req;
    we0     = !flush && (enq != 2'd0);
    we1     = !flush && (enq == 2'd2);
    head_d  = head_q + PTR_W'(deq);
    tail_d  = tail_q + PTR_W'(enq);
    count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    // Redirect wins: same-cycle fetch data is from the wrong path.
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign wdata0 = '{pc: fq.PCF1, instr: fq.InstrF1};
  assign wdata1 = '{pc: fq.PCF2, instr: fq.InstrF2};

  fq_storage #(.DEPTH(DEPTH)) u_storage (
    .clk    (clk),
    .rst    (rst),
    .we0    (we0),
    .widx0  (tail_q),
    .wdata0 (wdata0),
    .we1    (we1),
    .widx1  (tail_q + PTR_W'(1)),
    .wdata1 (wdata1),
    .ridx0  (head_q),
    .ridx1  (head_q + PTR_W'(1)),
    .rdata0 (rdata0),
    .rdata1 (rdata1)
  );

  always_comb begin
    fq.ReadyF  = ready;
    fq.Count   = count_q;
    fq.ValidD1 = count_q >= CNT_W'(1);
    fq.ValidD2 = count_q >= CNT_W'(2);
    fq.InstrD1 = fq.ValidD1 ? rdata0.instr : NOP_INSTR;
    fq.PCD1    = fq.ValidD1 ? rdata0.pc    : 32'h0;
    fq.InstrD2 = fq.ValidD2 ? rdata1.instr : NOP_INSTR;
    fq.PCD2    = fq.ValidD2 ? rdata1.pc    : 32'h0;
  end

  a_slot2_alone: assert property (@(posedge clk) disable iff (!rst)
    !(fq.ValidF2 && !fq.ValidF1))
    else $warning("fetch_queue: slot 2 valid without slot 1, slot 2 ignored");

  a_deq_over: assert property (@(posedge clk) disable iff (!rst)
    flush || (CNT_W'(deq_req) <= count_q))
    else $warning("fetch_queue: dequeue request exceeds occupancy, clamped");

  a_deq_three: assert property (@(posedge clk) disable iff (!rst)
    fq.DeqCnt != 2'd3)
    else $warning("fetch_queue: DeqCnt of 3 treated as 2");

endmodule
